bus_master_seq: RTL and testbench

Parametrised bus master sequencer for the SDSU bus. It writes NUM_OPS operands to register-file addresses 1..NUM_OPS, then issues a start command at address 0, and waits for the slave's `ready` with a timeout. It captures `result_data` and repeats while enabled. It replaces the fixed three-beat test master with a reset-able, handshake-correct, configurable master used as bench stimulus and as an on-chip traffic generator.

---
 rtl/bus_master_seq.sv | 146 ++++++++++++++
 tb/tb_bus_master_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bus_master_seq.sv
// SDSU bus master sequencer: writes NUM_OPS operands, issues a start command, then waits for ready or a timeout.
// Define BUS_MASTER_LFSR_EN to draw operands from a Galois LFSR seeded with SEED; otherwise a counter is used.
module bus_master_seq #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          NUM_OPS     = 2,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              ready,
  input  logic [DATA_W-1:0] result_data,
  output logic              valid,
  output logic              exec,
  output logic              write,
  output logic              start,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  output logic              timeout,
  output logic [15:0]       txn_count
);

  typedef enum logic [2:0] {IDLE, OP, GAP, CMD, WAIT, DONE} state_t;

`ifdef BUS_MASTER_LFSR_EN
  localparam logic [31:0] SRC_INIT = SEED;
`else
  // counter mode always starts at zero; SEED only matters for the LFSR
  localparam logic [31:0] SRC_INIT = SEED & 32'h0;
`endif
  localparam logic [3:0]  LAST_K = 4'(NUM_OPS - 1);
  localparam logic [15:0] TO_M1  = 16'(TIMEOUT_CYC - 1);

  function automatic logic [31:0] advance(input logic [31:0] s);
`ifdef BUS_MASTER_LFSR_EN
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
`else
    return s + 32'd1;
`endif
  endfunction

  state_t            state, nxt;
  logic [3:0]        k, k_d;
  logic [15:0]       wcnt, wcnt_d, txn_d;
  logic [31:0]       src, src_d;
  logic              valid_d, start_d, busy_d, rv_d, to_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d, res_d;

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    nxt    = state;
    k_d    = k;
    wcnt_d = wcnt;
    src_d  = src;
    addr_d = address;
    data_d = data;
    res_d  = result_out;
    txn_d  = txn_count;
    rv_d   = 1'b0;
    to_d   = 1'b0;
    case (state)
      IDLE: if (enable) begin
        nxt = OP;
        k_d = 4'd0;
      end
      OP:   nxt = GAP;
      GAP:  if (k < LAST_K) begin
        nxt = OP;
        k_d = k + 4'd1;
      end else begin
        nxt = CMD;
      end
      CMD: begin
        nxt    = WAIT;
        wcnt_d = 16'd0;
      end
      WAIT: if (ready) begin
        nxt   = DONE;
        res_d = result_data;
        rv_d  = 1'b1;
        txn_d = txn_count + 16'd1;
      end else if (wcnt == TO_M1) begin
        nxt  = IDLE;
        to_d = 1'b1;
      end else begin
        wcnt_d = wcnt + 16'd1;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (nxt == OP) begin
      addr_d = ADDR_W'({28'd0, k_d} + 32'd1);
      data_d = src[DATA_W-1:0];
      src_d  = advance(src);
    end else if (nxt == CMD) begin
      addr_d = '0;
      data_d = DATA_W'(32'd1);
    end
    valid_d = (nxt == OP) || (nxt == CMD);
    start_d = (nxt == CMD) || (nxt == WAIT);
    busy_d  = (nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      wcnt         <= '0;
      src          <= SRC_INIT;
      valid        <= 1'b0;
      exec         <= 1'b0;
      write        <= 1'b1;
      start        <= 1'b0;
      address      <= '0;
      data         <= '0;
      busy         <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      txn_count    <= '0;
    end else begin
      state        <= nxt;
      k            <= k_d;
      wcnt         <= wcnt_d;
      src          <= src_d;
      valid        <= valid_d;
      exec         <= valid_d;
      write        <= 1'b1;
      start        <= start_d;
      address      <= addr_d;
      data         <= data_d;
      busy         <= busy_d;
      result_out   <= res_d;
      result_valid <= rv_d;
      timeout      <= to_d;
      txn_count    <= txn_d;
    end
  end

endmodule

// File: tb/tb_bus_master_seq.sv
// Bench for bus_master_seq: randomized transactions against a timeline model of the bus protocol.
module tb_bus_master_seq;
  localparam int DW = 32, AW = 32, N = 2, TO = 4;

`ifdef BUS_MASTER_LFSR_EN
  localparam logic [31:0] INIT = 32'h0000_0001;
  localparam logic [31:0] EXP0 = 32'h0000_0001, EXP1 = 32'h8020_0003, EXP2 = 32'hC030_0002;
`else
  localparam logic [31:0] INIT = 32'h0;
  localparam logic [31:0] EXP0 = 32'd0, EXP1 = 32'd1, EXP2 = 32'd2;
`endif

  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, ready = 1'b0;
  logic [DW-1:0] result_data = '0;
  logic valid, exec, write, start, busy, result_valid, timeout;
  logic [AW-1:0] address;
  logic [DW-1:0] data, result_out;
  logic [15:0] txn_count;

  int vectors = 0, miscompares = 0;
  logic [31:0]   msrc;
  logic [15:0]   mtxn;
  logic [DW-1:0] mres, mdata;
  logic [AW-1:0] maddr;
  logic [DW-1:0] seen[$];

  always #5 clk = ~clk;

  bus_master_seq #(.DATA_W(DW), .ADDR_W(AW), .NUM_OPS(N), .TIMEOUT_CYC(TO), .SEED(32'h1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ready(ready), .result_data(result_data),
    .valid(valid), .exec(exec), .write(write), .start(start), .address(address), .data(data),
    .busy(busy), .result_out(result_out), .result_valid(result_valid), .timeout(timeout),
    .txn_count(txn_count)
  );

  function automatic logic [31:0] next_op(input logic [31:0] s);
`ifdef BUS_MASTER_LFSR_EN
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
`else
    return s + 32'd1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input bit v, input bit s, input bit b, input bit rv, input bit to);
    chk({tag, ".valid"}, 64'(valid), 64'(v));
    chk({tag, ".exec"}, 64'(exec), 64'(v));
    chk({tag, ".write"}, 64'(write), 64'd1);
    chk({tag, ".start"}, 64'(start), 64'(s));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".address"}, 64'(address), 64'(maddr));
    chk({tag, ".data"}, 64'(data), 64'(mdata));
    chk({tag, ".result_out"}, 64'(result_out), 64'(mres));
    chk({tag, ".result_valid"}, 64'(result_valid), 64'(rv));
    chk({tag, ".timeout"}, 64'(timeout), 64'(to));
    chk({tag, ".txn_count"}, 64'(txn_count), 64'(mtxn));
  endtask

  task automatic model_reset();
    msrc = INIT; mtxn = '0; mres = '0; mdata = '0; maddr = '0;
  endtask

  // Caller is in an IDLE cycle. d = WAIT cycles before ready (d >= TO means no ready).
  task automatic run_txn(input int d, input bit keep_en);
    enable = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      enable = keep_en ? 1'b1 : 1'($urandom_range(0, 1));
      ready  = 1'($urandom_range(0, 1));
      maddr  = AW'(i + 1);
      mdata  = msrc[DW-1:0];
      msrc   = next_op(msrc);
      seen.push_back(data);
      expect_o("op", 1, 0, 1, 0, 0);
      tick();
      expect_o("gap", 0, 0, 1, 0, 0);
    end
    tick();
    maddr = '0;
    mdata = DW'(1);
    expect_o("cmd", 1, 1, 1, 0, 0);
    for (int j = 0; j < TO; j++) begin
      tick();
      expect_o("wait", 0, 1, 1, 0, 0);
      if (j == d) begin
        ready = 1'b1;
        result_data = $urandom;
        break;
      end
      ready = 1'b0;
      result_data = $urandom;
    end
    tick();
    if (d < TO) begin
      mres = result_data;
      mtxn = mtxn + 16'd1;
      expect_o("done", 0, 0, 1, 1, 0);
      ready = 1'($urandom_range(0, 1));
      result_data = $urandom;
      tick();
      expect_o("idle_after", 0, 0, 0, 0, 0);
    end else begin
      expect_o("tout", 0, 0, 0, 0, 1);
    end
    ready = 1'b0;
    enable = keep_en;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    tick(); tick();
    expect_o("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      expect_o("idle_noen", 0, 0, 0, 0, 0);
    end

    run_txn(1, 0);
    chk("first_op0", 64'(seen[0]), 64'(EXP0[DW-1:0]));
    chk("first_op1", 64'(seen[1]), 64'(EXP1[DW-1:0]));
    tick();
    expect_o("idle_gap", 0, 0, 0, 0, 0);

    run_txn(0, 1);
    chk("second_op0", 64'(seen[2]), 64'(EXP2[DW-1:0]));
    run_txn(2, 1);
    run_txn(TO, 1);
    run_txn(TO - 1, 0);

    for (int t = 0; t < 30; t++)
      run_txn(int'($urandom_range(0, TO + 1)), 1'($urandom_range(0, 1)));

    // asynchronous reset in the middle of WAIT
    enable = 1'b1;
    repeat (2 * N + 2) tick();
    chk("pre_rst_start", 64'(start), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    expect_o("async_rst", 0, 0, 0, 0, 0);
    tick();
    expect_o("rst_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    seen.delete();
    run_txn(1, 0);
    chk("restart_op0", 64'(seen[0]), 64'(EXP0[DW-1:0]));
    chk("restart_op1", 64'(seen[1]), 64'(EXP1[DW-1:0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
